rca_word_sequencer: RTL
=======================

// Module: rca_word_sequencer
// PURPOSE
//  Adds WIDTH-bit operands with one 4-bit ripple-carry slice used over several cycles.
//  The slice processes one nibble per cycle, starting at the least significant nibble.
//  A registered carry links each nibble to the next.
//  Operands enter and results leave through valid/ready handshakes.
//  Intended for area-constrained datapaths where a full-width adder is not justified.
// PARAMETERS
//  WIDTH   16  operand/result width; multiple of SLICE_W, >= SLICE_W (elaboration error otherwise)
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      operand pair a/b/cin valid
//  in_ready   out  1      sequencer can accept operands
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  cin        in   1      carry into nibble 0
//  out_valid  out  1      sum/cout valid
//  out_ready  in   1      downstream accepts result
//  sum        out  WIDTH  a + b + cin, modulo 2^WIDTH
//  cout       out  1      carry out of the MSB
//  ovf        out  1      signed overflow (only when RCA_SEQ_OVF_EN is defined)
// BEHAVIOUR
//  - NSLICE = WIDTH/SLICE_W. Slice counter idx is max($clog2(NSLICE),1) bits wide.
//  - Reset (async assert, sync release): state=IDLE, idx=0, carry reg=0,
//    operand/sum regs=0, in_ready=0, out_valid=0, sum=0, cout=0, ovf=0.
//  - FSM:
//    - IDLE: in_ready=1. On in_valid&in_ready: latch a, b, cin into carry reg; idx=0; go to RUN.
//    - RUN: slice adds a[idx], b[idx] and carry reg. Result nibble is written to sum[idx];
//      slice cout is written to carry reg. idx increments each cycle.
//      When idx==NSLICE-1: go to DONE and write cout from the slice carry.
//    - DONE: out_valid=1. sum, cout and ovf are held stable until out_ready.
//      On out_ready: go to IDLE.
//  - Latency: handshake in cycle 0. RUN occupies cycles 1..NSLICE. out_valid rises in cycle NSLICE+1.
//  - Throughput: one result per NSLICE+2 cycles at best.
//    No accept is possible in the same cycle as a result handshake.
//  - in_ready=0 in RUN and DONE. in_valid is ignored there, and a/b/cin changes have no effect.
//  - sum and cout are registered. They show the last result until the next DONE.
//    Only the bits being written change during RUN.
//  - If rst_n falls mid-RUN or mid-DONE, the operation is abandoned. Everything returns to reset values.
//    No partial result is signalled.
//  - out_ready while out_valid=0 has no effect.
//  - NSLICE==1: RUN lasts exactly one cycle.
// CONFIGURATION
//  RCA_SEQ_OVF_EN defined:
//    - port ovf exists. It is written when entering DONE and held while DONE.
//    - ovf = (a[MSB]==b[MSB]) & (sum[MSB]!=a[MSB]).
//    - ovf is 0 at reset.
//  RCA_SEQ_OVF_EN undefined: port ovf and its logic are absent. Nothing else changes.
// STRUCTURE
//  - Package rca_seq_pkg:
//    - SLICE_W=4.
//    - enum state_t {IDLE, RUN, DONE}, 2 bits.
//    - function nslice(width).
//  - Sub-module rca4_slice: combinational 4-bit ripple-carry slice, ports (a,b,cin -> s,cout).
//    Instantiated once.
//  - All sequencing, the operand registers and the result register live in rca_word_sequencer.
// TESTING (WIDTH=16 unless noted)
//  1. a=0x1234 b=0x4321 cin=0 -> out_valid in cycle 5, sum=0x5555, cout=0.
//  2. a=0xFFFF b=0x0001 cin=0 -> sum=0x0000, cout=1. Also a=0xFFFF b=0x0000 cin=1 -> sum=0x0000, cout=1.
//  3. out_ready low for 5 cycles after out_valid -> sum, cout and out_valid stable, in_ready=0.
//     Raising out_ready gives IDLE next cycle.
//  4. rst_n pulsed low at RUN idx=2 -> all outputs 0 immediately, in_ready=1 after release.
//     Then 0x0F0F+0x00F1 -> sum=0x1000, cout=0.
//  5. in_valid held high with changing a/b during RUN -> only the first pair is used.
//     The second pair is accepted only after the result handshake.
//  6. RCA_SEQ_OVF_EN: 0x7FFF+0x0001 -> ovf=1. 0x8000+0x8000 -> ovf=1, cout=1, sum=0.
//     WIDTH=4: 0x7+0x9 -> sum=0x0, cout=1 in cycle 2.

Source files
------------

// File: rtl/rca_seq_pkg.sv
// rca_seq_pkg: shared slice width, sequencer state encoding and slice-count helper
package rca_seq_pkg;
  localparam int SLICE_W = 4;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic int nslice(input int width);
    return width / SLICE_W;
  endfunction
endpackage

// File: rtl/rca4_slice.sv
// rca4_slice: combinational 4-bit ripple-carry adder slice
module rca4_slice
  import rca_seq_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] s,
  output logic               cout
);
  logic [SLICE_W:0] c;
  assign c[0] = cin;
  for (genvar i = 0; i < SLICE_W; i++) begin : g_bit
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign cout = c[SLICE_W];
endmodule

// File: rtl/rca_word_sequencer.sv
// rca_word_sequencer: WIDTH-bit adder reusing one 4-bit slice, one nibble per cycle, LSB first.
// Optional signed-overflow output ovf_o enabled by defining RCA_SEQ_OVF_EN.
module rca_word_sequencer
  import rca_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
`ifdef RCA_SEQ_OVF_EN
  ,
  output logic             ovf_o
`endif
);
  localparam int NSLICE = nslice(WIDTH);
  localparam int IW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  if ((WIDTH % SLICE_W) != 0 || WIDTH < SLICE_W) begin : g_bad_width
    $error("WIDTH must be a positive multiple of SLICE_W");
  end
  state_t             state_q;
  logic [IW-1:0]      idx_q;
  logic               carry_q;
  logic [WIDTH-1:0]   a_q, b_q, sum_q;
  logic               in_ready_q, out_valid_q, cout_q;
  logic [SLICE_W-1:0] a_n, b_n, s_n;
  logic               c_n, last;
`ifdef RCA_SEQ_OVF_EN
  logic               ovf_q;
  assign ovf_o = ovf_q;
`endif
  always_comb begin
    a_n = '0;
    b_n = '0;
    for (int k = 0; k < NSLICE; k++) begin
      if (int'(idx_q) == k) begin
        a_n = a_q[k*SLICE_W +: SLICE_W];
        b_n = b_q[k*SLICE_W +: SLICE_W];
      end
    end
  end
  assign last = int'(idx_q) == NSLICE - 1;
  rca4_slice u_slice (
    .a   (a_n),
    .b   (b_n),
    .cin (carry_q),
    .s   (s_n),
    .cout(c_n)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      cout_q      <= 1'b0;
`ifdef RCA_SEQ_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (in_valid_i && in_ready_q) begin
            a_q        <= a_i;
            b_q        <= b_i;
            carry_q    <= cin_i;
            idx_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= RUN;
          end
        end
        RUN: begin
          for (int k = 0; k < NSLICE; k++) begin
            if (int'(idx_q) == k) sum_q[k*SLICE_W +: SLICE_W] <= s_n;
          end
          carry_q <= c_n;
          idx_q   <= idx_q + IW'(1);
          if (last) begin
            idx_q       <= '0;
            cout_q      <= c_n;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
`ifdef RCA_SEQ_OVF_EN
            ovf_q       <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (s_n[SLICE_W-1] != a_q[WIDTH-1]);
`endif
          end
        end
        DONE: begin
          if (out_ready_i) begin
            out_valid_o_clear();
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  task automatic out_valid_o_clear();
    out_valid_q <= 1'b0;
    in_ready_q  <= 1'b1;
    state_q     <= IDLE;
  endtask
  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign sum_o       = sum_q;
  assign cout_o      = cout_q;
endmodule
